add_seq_ctrl: RTL and testbench

Multi-cycle sequencer that computes WIDTH-bit additions by issuing one 4-bit slice per cycle to a single shared 4-bit carry-select adder slice. Operands enter through a valid/ready handshake and are held in registers. The slice carry is registered between cycles, and the assembled sum is presented through a second valid/ready handshake. The block sits between an operand producer (register file or test driver) and a result consumer. It replaces a full-width ripple adder when area matters more than latency.

---
 rtl/add_seq_pkg.sv | 21 ++
 rtl/add4_slice.sv | 35 +++
 rtl/add_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_add_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the slice-serial adder sequencer.
// Optional subtract support is enabled with ADDSEQ_SUB_EN.
package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int w);
        return w / SLICE_W;
    endfunction

    function automatic int idx_width(input int w);
        return (w / SLICE_W > 1) ? $clog2(w / SLICE_W) : 1;
    endfunction

endpackage

// File: rtl/add4_slice.sv
// 4-bit carry-select adder slice: both carry-in cases are
// rippled in parallel and the real carry-in picks one.
module add4_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c_o
);

    logic [SLICE_W-1:0] s0;
    logic [SLICE_W-1:0] s1;
    logic [SLICE_W:0]   c0;
    logic [SLICE_W:0]   c1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            s0[i]   = a_i[i] ^ b_i[i] ^ c0[i];
            c0[i+1] = (a_i[i] & b_i[i]) | (c0[i] & (a_i[i] ^ b_i[i]));
            s1[i]   = a_i[i] ^ b_i[i] ^ c1[i];
            c1[i+1] = (a_i[i] & b_i[i]) | (c1[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign s_o = c_i ? s1 : s0;
    assign c_o = c_i ? c1[SLICE_W] : c0[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Slice-serial WIDTH-bit adder: one 4-bit slice per cycle, carry held
// in carry_q. Define ADDSEQ_SUB_EN to add the sub port (a - b).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADDSEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = num_slices(WIDTH);
    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic               accept;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_co;

`ifdef ADDSEQ_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;
`else
    assign b_eff   = b;
    assign cin_eff = c_in;
`endif

    assign accept = in_valid && in_ready;

    add4_slice u_slice (
        .a_i (a_q[idx_q*SLICE_W +: SLICE_W]),
        .b_i (b_q[idx_q*SLICE_W +: SLICE_W]),
        .c_i (carry_q),
        .s_o (sl_s),
        .c_o (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)       state_d = RUN;
            RUN:  if (idx_q == LAST)  state_d = DONE;
            DONE: if (out_ready)      state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_eff;
            carry_d = cin_eff;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
            carry_d = sl_co;
            // idx parks on the last slice rather than wrapping
            if (idx_q != LAST) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = carry_q;
    assign ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl at WIDTH=16; subtract cases
// are exercised when ADDSEQ_SUB_EN is defined.
module tb_add_seq_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   f;
        exp_t         e;
        be   = ms ? ~mb : mb;
        ce   = ms ? 1'b1 : mc;
        f    = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ce};
        e.s  = f[W-1:0];
        e.co = f[W];
        e.ov = (ma[W-1] == be[W-1]) && (f[W-1] != ma[W-1]);
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is,
                         output int t_acc, output bit ok);
        logic rdy;
        ok       = 1'b0;
        t_acc    = 0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        c_in     = ic;
`ifdef ADDSEQ_SUB_EN
        sub      = is;
`endif
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok    = 1'b1;
                t_acc = cyc;
                q.push_back(model(ia, ib, ic, is));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t_v, output bit ok);
        ok  = 1'b0;
        t_v = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok  = 1'b1;
                t_v = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub       = 1'b0;
`endif
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, out_valid, busy, c_out, ovf, sum} !== {5'b10000, 16'h0}) begin
            failures++;
            $display("FAIL reset: got rdy=%b vld=%b busy=%b co=%b ov=%b sum=%h",
                     in_ready, out_valid, busy, c_out, ovf, sum);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] ta[5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'hA5A5, 16'h8000};
        logic [W-1:0] tb[5] = '{16'h0001, 16'h0001, 16'h4321, 16'h5A5B, 16'h8000};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int   t_acc, t_v;
        bit   ok;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            issue(ta[k], tb[k], tc[k], 1'b0, t_acc, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL add%0d_accept: no accept, required within 50 cycles", k);
                return;
            end
            wait_out(t_v, ok);
            checks++;
            if (!ok || (t_v - t_acc) != NS) begin
                failures++;
                $display("FAIL add%0d_latency: got %0d (ok=%0b) required %0d",
                         k, t_v - t_acc, ok, NS);
                if (!ok) return;
            end
            e = q.pop_front();
            checks++;
            if ({sum, c_out, ovf} !== e) begin
                failures++;
                $display("FAIL add%0d_result: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                         k, sum, c_out, ovf, e.s, e.co, e.ov);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                failures++;
                $display("FAIL add%0d_drain: got vld=%b rdy=%b required vld=0 rdy=1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int   t_acc, t_v;
        bit   ok;
        exp_t e;
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, t_acc, ok);
        if (ok) wait_out(t_v, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_start: no result within bound");
            return;
        end
        e = q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, sum, c_out, ovf} !== {2'b10, e}) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h co=%b ov=%b required vld=1 rdy=0 sum=%h",
                         i, out_valid, in_ready, sum, c_out, ovf, e.s);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midrun();
        int   t_acc, t_v;
        bit   ok;
        exp_t e;
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, t_acc, ok);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: got busy=%b ok=%0b required busy=1", busy, ok);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, c_out, ovf, sum} !== {5'b10000, 16'h0}) begin
            failures++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b co=%b ov=%b sum=%h",
                     in_ready, out_valid, busy, c_out, ovf, sum);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, t_acc, ok);
        if (ok) wait_out(t_v, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrun_next: no result within bound");
            return;
        end
        e = q.pop_front();
        checks++;
        if ({sum, c_out, ovf} !== e) begin
            failures++;
            $display("FAIL midrun_result: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                     sum, c_out, ovf, e.s, e.co, e.ov);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta[3] = '{16'h0005, 16'h8000, 16'h0009};
        logic [W-1:0] tb[3] = '{16'h0007, 16'h0001, 16'h0003};
        int   t_acc, t_v;
        bit   ok;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            issue(ta[k], tb[k], 1'b0, 1'b1, t_acc, ok);
            if (ok) wait_out(t_v, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL sub%0d_start: no result within bound", k);
                return;
            end
            e = q.pop_front();
            checks++;
            if ({sum, c_out, ovf} !== e) begin
                failures++;
                $display("FAIL sub%0d_result: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                         k, sum, c_out, ovf, e.s, e.co, e.ov);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask
`endif

    task automatic test_back_to_back();
        int           acc_cyc[$];
        int           results = 0;
        logic         acc, fire;
        logic [W-1:0] oa, ob, os;
        logic         oc, oco, oov;
        exp_t         e;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h0F0F;
        b         = 16'h00F1;
        c_in      = 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub       = 1'b0;
`endif
        for (int i = 0; i < 150; i++) begin
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            oa   = a;
            ob   = b;
            oc   = c_in;
            os   = sum;
            oco  = c_out;
            oov  = ovf;
            @(posedge clk);
            #1;
            if (acc) begin
                q.push_back(model(oa, ob, oc, 1'b0));
                acc_cyc.push_back(cyc);
            end
            if (fire) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious: result sum=%h with nothing pending", os);
                end else begin
                    e = q.pop_front();
                    results++;
                    if ({os, oco, oov} !== e) begin
                        failures++;
                        $display("FAIL b2b_result%0d: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                                 results, os, oco, oov, e.s, e.co, e.ov);
                    end
                end
            end
            a    = W'($urandom);
            b    = W'($urandom);
            c_in = 1'($urandom);
            if (i == 40) in_valid = 1'b0;
            if (i > 40 && q.size() == 0 && in_ready) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (q.size() != 0 || results < 5) begin
            failures++;
            $display("FAIL b2b_count: got results=%0d pending=%0d required >=5 and 0",
                     results, q.size());
        end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != NS + 2) begin
                failures++;
                $display("FAIL b2b_interval%0d: got %0d required %0d",
                         k, acc_cyc[k] - acc_cyc[k-1], NS + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_reset_midrun();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
